// File: rtl/morse_pkg.sv
// Shared Morse serializer types: FSM states, element/gap lengths in units,
// and the 16-entry code table (element count + MSB-first dash mask).
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    CGAP
  } state_e;

  localparam int unsigned DOT_UNITS  = 1;
  localparam int unsigned DASH_UNITS = 3;
  localparam int unsigned ELEM_GAP   = 1;
  localparam int unsigned CHAR_GAP   = 3;
  localparam int unsigned WORD_GAP   = 7;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_entry_t;

  // pattern bit 4 is the first element; 1 = dash, 0 = dot
  localparam morse_entry_t PATTERN_TABLE [16] = '{
    '{len: 3'd5, pattern: 5'b11111},  // 0
    '{len: 3'd5, pattern: 5'b01111},  // 1
    '{len: 3'd5, pattern: 5'b00111},  // 2
    '{len: 3'd5, pattern: 5'b00011},  // 3
    '{len: 3'd5, pattern: 5'b00001},  // 4
    '{len: 3'd5, pattern: 5'b00000},  // 5
    '{len: 3'd5, pattern: 5'b10000},  // 6
    '{len: 3'd5, pattern: 5'b11000},  // 7
    '{len: 3'd5, pattern: 5'b11100},  // 8
    '{len: 3'd5, pattern: 5'b11110},  // 9
    '{len: 3'd2, pattern: 5'b01000},  // A
    '{len: 3'd4, pattern: 5'b10000},  // B
    '{len: 3'd4, pattern: 5'b10100},  // C
    '{len: 3'd3, pattern: 5'b10000},  // D
    '{len: 3'd1, pattern: 5'b00000},  // E
    '{len: 3'd4, pattern: 5'b00100}   // F
  };

endpackage

// File: rtl/morse_serializer_lut.sv
// Combinational code-to-pattern lookup; codes 10..15 become a word space
// when hex letters are disabled.
module morse_lut
  import morse_pkg::*;
(
  input  logic [3:0] in_code,
  input  logic       hex_en,
  output logic [2:0] len,
  output logic [4:0] pattern,
  output logic       is_space
);

  morse_entry_t entry;

  always_comb begin
    entry    = PATTERN_TABLE[in_code];
    len      = entry.len;
    pattern  = entry.pattern;
    is_space = !hex_en && (in_code >= 4'd10);
  end

endmodule

// File: rtl/morse_serializer.sv
// Serializes one 4-bit code at a time into Morse keying with unit-accurate
// marks, element gaps and a single character gap.
module morse_serializer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter bit          HEX_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       sym_done
);

  localparam logic [15:0] CYC_MAX = 16'(UNIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [2:0]  unit_q, unit_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  left_q, left_d;
  logic [4:0]  pat_q, pat_d;
  logic        key_q, key_d;
  logic        sym_done_q, sym_done_d;

  logic [2:0]  lut_len;
  logic [4:0]  lut_pat;
  logic        lut_space;
  logic        tick, phase_end;

  morse_lut u_lut (
    .in_code  (in_code),
    .hex_en   (HEX_EN),
    .len      (lut_len),
    .pattern  (lut_pat),
    .is_space (lut_space)
  );

  assign tick      = (cyc_q == CYC_MAX);
  assign phase_end = tick && (unit_q == len_q - 3'd1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    len_d   = len_q;
    left_d  = left_q;
    pat_d   = pat_q;
    if (state_q != IDLE) begin
      if (tick) begin
        cyc_d  = '0;
        unit_d = unit_q + 3'd1;
      end else begin
        cyc_d = cyc_q + 16'd1;
      end
    end
    unique case (state_q)
      IDLE: if (in_valid) begin
        cyc_d  = '0;
        unit_d = '0;
        if (lut_space) begin
          state_d = CGAP;
          len_d   = 3'(WORD_GAP);
        end else begin
          state_d = MARK;
          len_d   = lut_pat[4] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
          pat_d   = {lut_pat[3:0], 1'b0};
          left_d  = lut_len - 3'd1;
        end
      end
      MARK: if (phase_end) begin
        unit_d = '0;
        if (left_q != '0) begin
          state_d = SPACE;
          len_d   = 3'(ELEM_GAP);
        end else begin
          // last element goes straight to the character gap, no element gap
          state_d = CGAP;
          len_d   = 3'(CHAR_GAP);
        end
      end
      SPACE: if (phase_end) begin
        unit_d  = '0;
        state_d = MARK;
        len_d   = pat_q[4] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        pat_d   = {pat_q[3:0], 1'b0};
        left_d  = left_q - 3'd1;
      end
      CGAP: if (phase_end) begin
        unit_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    key_d = (state_d == MARK);
    // registered pulse: flag the upcoming cycle if it is the final CGAP cycle
    sym_done_d = (state_d == CGAP) && (cyc_d == CYC_MAX) && (unit_d == len_d - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      unit_q     <= '0;
      len_q      <= '0;
      left_q     <= '0;
      pat_q      <= '0;
      key_q      <= 1'b0;
      sym_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      unit_q     <= unit_d;
      len_q      <= len_d;
      left_q     <= left_d;
      pat_q      <= pat_d;
      key_q      <= key_d;
      sym_done_q <= sym_done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign key_out  = key_q;
  assign sym_done = sym_done_q;

endmodule
